// File: rtl/adc_xy_plot_ctrl_if.sv
// Stream, control and status bundle for adc_xy_plot_ctrl.
// slave = the plot controller, master = the ADC/framebuffer environment around it.
`timescale 1ns/1ps
interface adc_xy_plot_ctrl_if #(
    parameter int unsigned ADC_DATA_BITS = 10,
    parameter int unsigned PIXEL_BITS    = 12,
    parameter int unsigned FB_X_BITS     = 10,
    parameter int unsigned FB_Y_BITS     = 9
);
    logic                     s_tvalid;
    logic                     s_tready;
    logic [ADC_DATA_BITS-1:0] s_x;
    logic [ADC_DATA_BITS-1:0] s_y;
    logic                     s_red;
    logic                     s_grn;
    logic                     s_blu;
    logic                     clear_req;
    logic                     m_pvalid;
    logic                     m_pready;
    logic [FB_X_BITS-1:0]     m_x;
    logic [FB_Y_BITS-1:0]     m_y;
    logic [PIXEL_BITS-1:0]    m_color;
    logic                     m_last;
    logic                     vga_enable;
    logic                     adc_enable;
    logic                     clearing;

    modport master (
        output s_tvalid, s_x, s_y, s_red, s_grn, s_blu, clear_req, m_pready,
        input  s_tready, m_pvalid, m_x, m_y, m_color, m_last, vga_enable, adc_enable, clearing
    );

    modport slave (
        input  s_tvalid, s_x, s_y, s_red, s_grn, s_blu, clear_req, m_pready,
        output s_tready, m_pvalid, m_x, m_y, m_color, m_last, vga_enable, adc_enable, clearing
    );
endinterface

// File: rtl/adc_xy_plot_ctrl.sv
// XY-plot controller: clears the framebuffer, then maps ADC (x,y,rgb) samples to pixel writes.
// Define ADC_XY_PLOT_CTRL_DEDUP_EN to drop samples that repeat the last emitted RUN pixel.
`timescale 1ns/1ps
module adc_xy_plot_ctrl #(
    parameter int unsigned ADC_DATA_BITS = 10,
    parameter int unsigned PIXEL_BITS    = 12,
    parameter int unsigned FB_WIDTH      = 640,
    parameter int unsigned FB_HEIGHT     = 480,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter bit          X_INVERT      = 1'b1,
    parameter bit          Y_INVERT      = 1'b0,
    parameter logic [PIXEL_BITS-1:0] CLEAR_COLOR = '0
) (
    input logic              clk,
    input logic              reset,
    adc_xy_plot_ctrl_if.slave bus
);
    localparam int unsigned COLOR_BITS = PIXEL_BITS / 3;
    localparam int unsigned FB_X_BITS  = $clog2(FB_WIDTH);
    localparam int unsigned FB_Y_BITS  = $clog2(FB_HEIGHT);
    localparam int unsigned XP_BITS    = ADC_DATA_BITS + FB_X_BITS + 1;
    localparam int unsigned YP_BITS    = ADC_DATA_BITS + FB_Y_BITS + 1;
    localparam int unsigned SET_BITS   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [FB_X_BITS-1:0]     XMax       = FB_X_BITS'(FB_WIDTH - 1);
    localparam logic [FB_Y_BITS-1:0]     YMax       = FB_Y_BITS'(FB_HEIGHT - 1);
    localparam logic [ADC_DATA_BITS-1:0] AdcMax     = '1;
    localparam logic [SET_BITS-1:0]      SettleLast = SET_BITS'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {StClear, StSettle, StRun, StDrain} state_e;

    state_e                state_q, state_d;
    logic [FB_X_BITS-1:0]  cx_q, cx_d;
    logic [FB_Y_BITS-1:0]  cy_q, cy_d;
    logic                  clr_done_q, clr_done_d;
    logic [SET_BITS-1:0]   settle_q, settle_d;
    logic                  vga_en_q, vga_en_d;
    logic                  ovalid_q, ovalid_d;
    logic [FB_X_BITS-1:0]  ox_q, ox_d;
    logic [FB_Y_BITS-1:0]  oy_q, oy_d;
    logic [PIXEL_BITS-1:0] ocol_q, ocol_d;
    logic                  olast_q, olast_d;

    logic                     out_free;
    logic                     tready;
    logic                     run_load;
    logic                     dedup_drop;
    logic [ADC_DATA_BITS-1:0] xi, yi;
    logic [FB_X_BITS-1:0]     px;
    logic [FB_Y_BITS-1:0]     py;
    logic [PIXEL_BITS-1:0]    pcol;

    // Products are formed at full width so the scaled result stays below the framebuffer size.
    assign xi   = X_INVERT ? (AdcMax - bus.s_x) : bus.s_x;
    assign yi   = Y_INVERT ? (AdcMax - bus.s_y) : bus.s_y;
    assign px   = FB_X_BITS'((XP_BITS'(xi) * XP_BITS'(FB_WIDTH)) >> ADC_DATA_BITS);
    assign py   = FB_Y_BITS'((YP_BITS'(yi) * YP_BITS'(FB_HEIGHT)) >> ADC_DATA_BITS);
    assign pcol = PIXEL_BITS'({{COLOR_BITS{bus.s_red}}, {COLOR_BITS{bus.s_grn}},
                               {COLOR_BITS{bus.s_blu}}});

    assign out_free = !ovalid_q || bus.m_pready;

`ifdef ADC_XY_PLOT_CTRL_DEDUP_EN
    logic                  hist_valid_q;
    logic [FB_X_BITS-1:0]  hist_x_q;
    logic [FB_Y_BITS-1:0]  hist_y_q;
    logic [PIXEL_BITS-1:0] hist_col_q;

    assign dedup_drop = hist_valid_q && (hist_x_q == px) && (hist_y_q == py) &&
                        (hist_col_q == pcol);

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_valid_q <= 1'b0;
            hist_x_q     <= '0;
            hist_y_q     <= '0;
            hist_col_q   <= '0;
        end else if (state_q == StDrain && state_d == StClear) begin
            hist_valid_q <= 1'b0;
        end else if (run_load) begin
            hist_valid_q <= 1'b1;
            hist_x_q     <= px;
            hist_y_q     <= py;
            hist_col_q   <= pcol;
        end
    end
`else
    assign dedup_drop = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        clr_done_d = clr_done_q;
        settle_d   = settle_q;
        vga_en_d   = vga_en_q;
        ovalid_d   = ovalid_q && !bus.m_pready;
        ox_d       = ox_q;
        oy_d       = oy_q;
        ocol_d     = ocol_q;
        olast_d    = olast_q;
        tready     = 1'b0;
        run_load   = 1'b0;

        unique case (state_q)
            StClear: begin
                if (ovalid_q && bus.m_pready && olast_q) begin
                    olast_d = 1'b0;
                    if (SETTLE_CYCLES == 0) begin
                        state_d  = StRun;
                        vga_en_d = 1'b1;
                    end else begin
                        state_d  = StSettle;
                        settle_d = '0;
                    end
                end else if (!clr_done_q && out_free) begin
                    // Raster counter runs one pixel ahead of the output register.
                    ovalid_d = 1'b1;
                    ox_d     = cx_q;
                    oy_d     = cy_q;
                    ocol_d   = CLEAR_COLOR;
                    olast_d  = (cx_q == XMax) && (cy_q == YMax);
                    if (cx_q == XMax) begin
                        cx_d = '0;
                        if (cy_q == YMax) begin
                            clr_done_d = 1'b1;
                        end else begin
                            cy_d = cy_q + FB_Y_BITS'(1);
                        end
                    end else begin
                        cx_d = cx_q + FB_X_BITS'(1);
                    end
                end
            end
            StSettle: begin
                if (settle_q == SettleLast) begin
                    state_d  = StRun;
                    vga_en_d = 1'b1;
                end else begin
                    settle_d = settle_q + SET_BITS'(1);
                end
            end
            StRun: begin
                tready = out_free;
                if (bus.s_tvalid && out_free && !dedup_drop) begin
                    run_load = 1'b1;
                    ovalid_d = 1'b1;
                    ox_d     = px;
                    oy_d     = py;
                    ocol_d   = pcol;
                    olast_d  = 1'b0;
                end
                if (bus.clear_req) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (!ovalid_q) begin
                    state_d    = StClear;
                    cx_d       = '0;
                    cy_d       = '0;
                    clr_done_d = 1'b0;
                end
            end
            default: state_d = StClear;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StClear;
            cx_q       <= '0;
            cy_q       <= '0;
            clr_done_q <= 1'b0;
            settle_q   <= '0;
            vga_en_q   <= 1'b0;
            ovalid_q   <= 1'b0;
            ox_q       <= '0;
            oy_q       <= '0;
            ocol_q     <= '0;
            olast_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            clr_done_q <= clr_done_d;
            settle_q   <= settle_d;
            vga_en_q   <= vga_en_d;
            ovalid_q   <= ovalid_d;
            ox_q       <= ox_d;
            oy_q       <= oy_d;
            ocol_q     <= ocol_d;
            olast_q    <= olast_d;
        end
    end

    assign bus.s_tready   = tready;
    assign bus.m_pvalid   = ovalid_q;
    assign bus.m_x        = ox_q;
    assign bus.m_y        = oy_q;
    assign bus.m_color    = ocol_q;
    assign bus.m_last     = olast_q;
    assign bus.vga_enable = vga_en_q;
    assign bus.adc_enable = (state_q == StRun);
    assign bus.clearing   = (state_q == StClear) || (state_q == StDrain);
endmodule
